frect_span: RTL and testbench
=============================

Name: frect_span

Overview:
- Filled-rectangle span scheduler that sits directly upstream of the fast line (horizontal span) stage.
- Takes a rectangle given by two signed corners, normalises and clips it to the screen, then issues one horizontal span per row.
- Each span is handed to the span stage via a start pulse plus x0/x1, and the block waits for that stage's done before moving to the next row.
- Holds the current row y stable so the downstream pixel writer can pair it with the span stage's x output.

Parameters:
- CORDW, 16, signed coordinate width (bits).
- SCR_W, 640, screen width in pixels; clip x range is 0..SCR_W-1.
- SCR_H, 480, screen height in pixels; clip y range is 0..SCR_H-1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin fill; sampled only in IDLE
- x0  in  CORDW  corner 0 x (signed)
- y0  in  CORDW  corner 0 y (signed)
- x1  in  CORDW  corner 1 x (signed)
- y1  in  CORDW  corner 1 y (signed)
- span_done  in  1  one-cycle completion pulse from span stage
- span_start  out  1  one-cycle request to span stage
- span_x0  out  CORDW  clipped left x of current span
- span_x1  out  CORDW  clipped right x of current span
- y  out  CORDW  current row, stable from span_start until the matching span_done
- busy  out  1  fill in progress
- done  out  1  fill complete, high one cycle

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0, outputs take these values:
  - state=IDLE
  - span_start=0, busy=0, done=0
  - y=0, span_x0=0, span_x1=0
- Reset mid-fill returns to IDLE immediately and abandons the fill; no done pulse is issued.
- States: IDLE, CLIP, ROW, WAIT, FIN.
- IDLE:
  - done=0.
  - On start: latch normalised bounds xa=min(x0,x1), xb=max(x0,x1), ya=min(y0,y1), yb=max(y0,y1).
  - Set busy=1 and go to CLIP.
- CLIP:
  - Clamp each bound to its axis: values <0 become 0, x bounds >SCR_W-1 become SCR_W-1, y bounds >SCR_H-1 become SCR_H-1.
  - The rectangle is empty if xb<0, xa>SCR_W-1, yb<0 or ya>SCR_H-1.
  - Empty: go to FIN; no span is issued.
  - Otherwise: load span_x0/span_x1 with the clipped x bounds, set y=clipped ya, go to ROW.
- ROW: span_start=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold y, span_x0 and span_x1.
  - On span_done with y==clipped yb: go to FIN.
  - On span_done otherwise: y<=y+1, go to ROW.
- FIN: busy<=0, done<=1 for one cycle, go to IDLE.
- Latency:
  - start to first span_start is 2 cycles (IDLE→CLIP→ROW).
  - span_done to the next span_start is 1 cycle.
  - Last span_done to done is 1 cycle.
  - Empty rectangle: done 2 cycles after start.
- All comparisons are signed at CORDW. SCR_W-1 and SCR_H-1 must be representable as positive CORDW values.
- y increments never overflow, because y never exceeds SCR_H-1.
- Handshake rules:
  - start is ignored while busy (CLIP/ROW/WAIT/FIN).
  - A start asserted in the same cycle as done is ignored; it must be re-asserted in IDLE.
  - span_done outside WAIT is ignored.
- Degenerate inputs:
  - x0==x1 gives one-pixel-wide spans.
  - y0==y1 gives a single span.
  - Corner order is irrelevant.
- Throughput is set entirely by the span stage; this block adds one idle cycle per row.

Decomposition:
- Shared gfx package holds:
  - State encodings and STATEW for IDLE/CLIP/ROW/WAIT/FIN.
  - A clamp helper function (value, lo, hi), reused by the line, triangle and circle stages.
- No sub-module inside this block. The span stage (fline) is instantiated alongside it in the fill top level, not inside it.
- Integration bench wires span_start/span_x0/span_x1 to fline's start/x0/x1 and fline's done to span_done.

Test Plan:
- Basic fill: start with (x0,y0)=(2,3), (x1,y1)=(5,4), span stage modelled with a 4-cycle done delay.
  - Required: exactly 2 span_start pulses, each with span_x0=2, span_x1=5.
  - First span at y=3, second at y=4.
  - done one cycle after the 2nd span_done.
  - busy high from the cycle after start through FIN.
- Reversed corners: (9,7)→(1,5).
  - Required: spans at y=5,6,7, each with x0=1, x1=9.
- Clipping (SCR_W=640, SCR_H=480): (-10,-2)→(700,1).
  - Required: spans at y=0 and y=1, each with span_x0=0, span_x1=639.
- Fully off-screen: (650,10)→(700,20), then separately (-5,-9)→(-1,-3).
  - Required: no span_start, done 2 cycles after start.
- Start while busy: pulse start again during WAIT with different corners.
  - Required: ignored; original span sequence and y values unchanged.
- Async reset mid-fill: drop rst_n between clock edges during WAIT of row 2.
  - Required: busy=0, span_start=0 and y=0 immediately, no done pulse.
  - A new start after release runs a normal fill.

Source files
------------

// File: rtl/frect_span_pkg.sv
// Shared gfx definitions for the fill and span schedulers: FSM encodings and a clamp helper.
// Clamp works at int width so callers of any CORDW can sign-extend into it and truncate back.
package frect_span_pkg;

    localparam int STATEW = 3;

    typedef enum logic [STATEW-1:0] {
        S_IDLE = 3'd0,
        S_CLIP = 3'd1,
        S_ROW  = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    function automatic int clamp(input int value, input int lo, input int hi);
        if (value < lo)
            return lo;
        else if (value > hi)
            return hi;
        else
            return value;
    endfunction

endpackage

// File: rtl/frect_span.sv
// Filled-rectangle span scheduler: normalises/clips a rectangle and issues one span per row.
// Latency: start->first span_start 2 cycles, span_done->next span_start 1, last span_done->done 1.
// Backpressure: waits for span_done from the span stage before each new row; start ignored while busy.
module frect_span
    import frect_span_pkg::*;
#(
    parameter int CORDW = 16,
    parameter int SCR_W = 640,
    parameter int SCR_H = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] x1,
    input  logic signed [CORDW-1:0] y1,
    input  logic                    span_done,
    output logic                    span_start,
    output logic signed [CORDW-1:0] span_x0,
    output logic signed [CORDW-1:0] span_x1,
    output logic signed [CORDW-1:0] y,
    output logic                    busy,
    output logic                    done
);

    localparam int XMAX = SCR_W - 1;
    localparam int YMAX = SCR_H - 1;

    state_t state;

    // Normalised bounds; yb is overwritten with its clipped value in CLIP.
    logic signed [CORDW-1:0] xa, xb, ya, yb;

    logic empty;
    assign empty = (int'(xb) < 0) || (int'(xa) > XMAX) ||
                   (int'(yb) < 0) || (int'(ya) > YMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            xa         <= '0;
            xb         <= '0;
            ya         <= '0;
            yb         <= '0;
            span_start <= 1'b0;
            span_x0    <= '0;
            span_x1    <= '0;
            y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xa    <= (x0 < x1) ? x0 : x1;
                        xb    <= (x0 < x1) ? x1 : x0;
                        ya    <= (y0 < y1) ? y0 : y1;
                        yb    <= (y0 < y1) ? y1 : y0;
                        busy  <= 1'b1;
                        state <= S_CLIP;
                    end
                end
                S_CLIP: begin
                    if (empty) begin
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        span_x0    <= CORDW'(clamp(int'(xa), 0, XMAX));
                        span_x1    <= CORDW'(clamp(int'(xb), 0, XMAX));
                        y          <= CORDW'(clamp(int'(ya), 0, YMAX));
                        yb         <= CORDW'(clamp(int'(yb), 0, YMAX));
                        span_start <= 1'b1;
                        state      <= S_ROW;
                    end
                end
                S_ROW: begin
                    span_start <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (span_done) begin
                        if (y == yb) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            y          <= y + 1'b1;
                            span_start <= 1'b1;
                            state      <= S_ROW;
                        end
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    span_start <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frect_span.sv
// Directed bench for frect_span: table of rectangles with hand-computed spans, plus
// hand-written sequences for start-while-busy and asynchronous reset mid-fill.
module tb_frect_span;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic signed [15:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic               span_done = 1'b0;
    logic               span_start;
    logic signed [15:0] span_x0, span_x1, y;
    logic               busy, done;

    int checks = 0;
    int failures = 0;

    frect_span #(.CORDW(16), .SCR_W(640), .SCR_H(480)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .span_done(span_done), .span_start(span_start),
        .span_x0(span_x0), .span_x1(span_x1), .y(y),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0, y0, x1, y1;
        int n;      // expected span count
        int ex0, ex1;
        int eya;    // expected first row
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one fill; span stage modelled as span_done 4 cycles after span_start.
    // With poke set, a conflicting start is pulsed during the first WAIT.
    task automatic run_fill(input vec_t v, input bit poke);
        int cyc, nspan, span_at, last_sd;
        bit got_done;
        logic signed [15:0] cur_y;
        @(negedge clk);
        x0 = 16'(v.x0); y0 = 16'(v.y0); x1 = 16'(v.x1); y1 = 16'(v.y1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        cyc = 1;
        chk("busy_after_start", int'(busy), 1);
        nspan = 0; span_at = -100; last_sd = -100; got_done = 0; cur_y = '0;
        while (!got_done && cyc < 400) begin
            span_done = 1'b0;
            start = 1'b0;
            if (span_start) begin
                if (nspan == 0)
                    chk("first_span_latency", cyc, 2);
                else
                    chk("done_to_next_span", cyc, last_sd + 1);
                chk("span_x0", int'(span_x0), v.ex0);
                chk("span_x1", int'(span_x1), v.ex1);
                chk("span_y", int'(y), v.eya + nspan);
                cur_y = y;
                span_at = cyc;
                nspan++;
            end
            if (cyc == span_at + 2) begin
                chk("y_hold_in_wait", int'(y), int'(cur_y));
                if (poke && nspan == 1) begin
                    x0 = 16'sd100; y0 = 16'sd100; x1 = 16'sd200; y1 = 16'sd300;
                    start = 1'b1;
                end
            end
            if (cyc == span_at + 4) begin
                span_done = 1'b1;
                last_sd = cyc;
            end
            if (done) begin
                got_done = 1;
                chk("busy_during_fin", int'(busy), 1);
                if (v.n == 0)
                    chk("empty_done_latency", cyc, 2);
                else
                    chk("last_done_to_done", cyc, last_sd + 1);
            end
            @(negedge clk);
            cyc++;
        end
        span_done = 1'b0;
        start = 1'b0;
        chk("done_seen", int'(got_done), 1);
        chk("span_count", nspan, v.n);
        chk("busy_after_fin", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic wait_span(output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (span_start) ok = 1;
        end
    endtask

    vec_t vecs[7];
    bit   ok;
    int   seen_done;

    initial begin
        vecs[0] = '{x0:2,   y0:3,   x1:5,   y1:4,   n:2, ex0:2,   ex1:5,   eya:3};
        vecs[1] = '{x0:9,   y0:7,   x1:1,   y1:5,   n:3, ex0:1,   ex1:9,   eya:5};
        vecs[2] = '{x0:-10, y0:-2,  x1:700, y1:1,   n:2, ex0:0,   ex1:639, eya:0};
        vecs[3] = '{x0:650, y0:10,  x1:700, y1:20,  n:0, ex0:0,   ex1:0,   eya:0};
        vecs[4] = '{x0:-5,  y0:-9,  x1:-1,  y1:-3,  n:0, ex0:0,   ex1:0,   eya:0};
        vecs[5] = '{x0:4,   y0:8,   x1:4,   y1:8,   n:1, ex0:4,   ex1:4,   eya:8};
        vecs[6] = '{x0:630, y0:475, x1:900, y1:900, n:5, ex0:630, ex1:639, eya:475};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_span_start", int'(span_start), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_span_x0", int'(span_x0), 0);
        chk("rst_span_x1", int'(span_x1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_fill(vecs[i], 1'b0);

        // Conflicting start during WAIT must not disturb the original sequence.
        run_fill(vecs[0], 1'b1);

        // Asynchronous reset between edges during the WAIT of row 2.
        @(negedge clk);
        x0 = 16'sd0; y0 = 16'sd0; x1 = 16'sd3; y1 = 16'sd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_span(ok);
        chk("rst_seq_span1", int'(ok), 1);
        repeat (3) @(negedge clk);
        span_done = 1'b1;
        @(negedge clk);
        span_done = 1'b0;
        chk("rst_seq_span2", int'(span_start), 1);
        chk("rst_seq_row2_y", int'(y), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_span_start", int'(span_start), 0);
        chk("arst_y", int'(y), 0);
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        chk("arst_no_done", seen_done, 0);

        run_fill(vecs[1], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
